// File: rtl/microc_ctrl_mc.sv
// -----------------------------------------------------------------------------
// microc_ctrl_mc -- multi-cycle control unit for the microc datapath.
//
// Each instruction takes three phases:
//   FETCH  : request the instruction word and wait for memory, with a timeout.
//   DECODE : latch Opcode into op_r.
//   EXEC   : drive the datapath strobes and selects for one cycle.
// The unit also tracks call depth (JAL/RET). HALT and ERROR are terminal
// states that hold until reset.
//
// Fetch handshake: mem_req is the valid/request and mem_ready is the
// response. The instruction word is accepted, and ir_we pulses, in the same
// cycle in which both mem_req and mem_ready are high. mem_ready is ignored
// whenever mem_req is low.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   Opcode     in   [5:0] opcode from the datapath IR (sampled in DECODE only)
//   zero       in   ALU zero flag (used in EXEC by JZ/JNZ)
//   mem_ready  in   instruction memory data valid
//   mem_req    out  instruction fetch request
//   ir_we      out  IR load strobe
//   pc_we      out  PC update strobe
//   s_inc      out  PC mux: 1 = PC+1, 0 = jump target
//   s_inm      out  regfile write-data mux: 1 = immediate, 0 = ALU
//   we         out  regfile write enable
//   wez        out  zero-flag register write enable
//   AluOP      out  [ALUOP_W-1:0] ALU operation
//   push       out  return-address stack push
//   pop        out  return-address stack pop
//   s_ret      out  PC mux override: 1 = return address
//   halted     out  HALT reached (sticky)
//   err        out  [1:0] 00 none, 01 fetch timeout, 10 overflow, 11 underflow
//   dbg_state  out  [2:0] current FSM state (debug observation)
//   dbg_sp     out  current call depth (debug observation)
// -----------------------------------------------------------------------------
module microc_ctrl_mc #(
  parameter int DEPTH    = 4,
  parameter int WAIT_MAX = 15,
  parameter int ALUOP_W  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [5:0]                   Opcode,
  input  logic                         zero,
  input  logic                         mem_ready,
  output logic                         mem_req,
  output logic                         ir_we,
  output logic                         pc_we,
  output logic                         s_inc,
  output logic                         s_inm,
  output logic                         we,
  output logic                         wez,
  output logic [ALUOP_W-1:0]           AluOP,
  output logic                         push,
  output logic                         pop,
  output logic                         s_ret,
  output logic                         halted,
  output logic [1:0]                   err,
  output logic [2:0]                   dbg_state,
  output logic [$clog2(DEPTH+1)-1:0]   dbg_sp
);

  localparam int SP_W   = $clog2(DEPTH + 1);
  localparam int WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic [SP_W-1:0]   DEPTH_SP  = SP_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX);

  // Instruction groups, selected by Opcode[4:2] when Opcode[5] = 1.
  localparam logic [2:0] G_LI   = 3'b000;
  localparam logic [2:0] G_J    = 3'b001;
  localparam logic [2:0] G_JZ   = 3'b010;
  localparam logic [2:0] G_JNZ  = 3'b011;
  localparam logic [2:0] G_JAL  = 3'b100;
  localparam logic [2:0] G_RET  = 3'b101;
  localparam logic [2:0] G_NOP  = 3'b110;
  localparam logic [2:0] G_HALT = 3'b111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_OVER    = 2'b10;
  localparam logic [1:0] ERR_UNDER   = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_HALT   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t              state;
  logic [5:0]          op_r;
  logic [SP_W-1:0]     sp;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [1:0]          err_r;
  logic                halted_r;

  // Decode helpers derived from the latched opcode.
  logic       is_alu;
  logic [2:0] grp;
  logic       jal_ok;
  logic       ret_ok;
  logic       op_low_unused;

  assign is_alu        = ~op_r[5];
  assign grp           = op_r[4:2];
  assign jal_ok        = (sp < DEPTH_SP);
  assign ret_ok        = (sp != '0);
  assign op_low_unused = ^op_r[1:0];

  // ---------------------------------------------------------------------------
  // State, call depth, fetch timeout counter and sticky status registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      op_r     <= '0;
      sp       <= '0;
      wait_cnt <= '0;
      err_r    <= ERR_NONE;
      halted_r <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            // Last permitted cycle expired without data: WAIT_MAX+1 cycles total.
            state <= S_ERROR;
            err_r <= ERR_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          op_r  <= Opcode;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          if (!is_alu) begin
            case (grp)
              G_JAL: begin
                if (jal_ok) begin
                  sp <= sp + 1'b1;
                end else begin
                  state <= S_ERROR;
                  err_r <= ERR_OVER;
                end
              end
              G_RET: begin
                if (ret_ok) begin
                  sp <= sp - 1'b1;
                end else begin
                  state <= S_ERROR;
                  err_r <= ERR_UNDER;
                end
              end
              G_HALT: begin
                state    <= S_HALT;
                halted_r <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_HALT:  state <= S_HALT;
        S_ERROR: state <= S_ERROR;
        default: state <= S_FETCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Strobes and selects. FETCH must answer mem_ready in the same cycle and
  // EXEC must follow the live zero flag, so these decode the registered state
  // combinationally. Every output is forced low while reset is asserted, so an
  // instruction interrupted by reset issues no further strobes.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    s_inc   = 1'b1;
    s_inm   = 1'b0;
    we      = 1'b0;
    wez     = 1'b0;
    AluOP   = '0;
    push    = 1'b0;
    pop     = 1'b0;
    s_ret   = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_EXEC: begin
        pc_we = 1'b1;
        if (is_alu) begin
          AluOP = op_r[1+ALUOP_W:2];
          we    = 1'b1;
          wez   = 1'b1;
        end else begin
          case (grp)
            G_LI: begin
              s_inm = 1'b1;
              we    = 1'b1;
            end
            G_J:   s_inc = 1'b0;
            G_JZ:  s_inc = ~zero;
            G_JNZ: s_inc = zero;
            G_JAL: begin
              if (jal_ok) begin
                push  = 1'b1;
                s_inc = 1'b0;
              end else begin
                pc_we = 1'b0;
              end
            end
            G_RET: begin
              if (ret_ok) begin
                pop   = 1'b1;
                s_ret = 1'b1;
              end else begin
                pc_we = 1'b0;
              end
            end
            G_NOP:  ;
            G_HALT: pc_we = 1'b0;
            default: ;
          endcase
        end
      end
      default: ;
    endcase

    if (!reset) begin
      mem_req = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      s_inc   = 1'b0;
      s_inm   = 1'b0;
      we      = 1'b0;
      wez     = 1'b0;
      AluOP   = '0;
      push    = 1'b0;
      pop     = 1'b0;
      s_ret   = 1'b0;
    end
  end

  assign halted    = halted_r;
  assign err       = err_r;
  assign dbg_state = state;
  assign dbg_sp    = sp;

endmodule

// File: tb/tb_microc_ctrl_mc.sv
// -----------------------------------------------------------------------------
// Bench for microc_ctrl_mc. The driver issues whole instructions (fetch waits,
// fetch, decode, exec) and pushes the output vector expected in every cycle,
// taken from an instruction-level model of the unit. A monitor pops one
// expected vector per cycle and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_microc_ctrl_mc;

  localparam int DEPTH    = 4;
  localparam int WAIT_MAX = 15;
  localparam int ALUOP_W  = 3;
  localparam int W        = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [5:0]         Opcode;
  logic               zero;
  logic               mem_ready;
  logic               mem_req, ir_we, pc_we, s_inc, s_inm, we, wez;
  logic [ALUOP_W-1:0] AluOP;
  logic               push, pop, s_ret, halted;
  logic [1:0]         err;
  logic [2:0]         dbg_state_unused;
  logic [2:0]         dbg_sp;

  microc_ctrl_mc #(.DEPTH(DEPTH), .WAIT_MAX(WAIT_MAX), .ALUOP_W(ALUOP_W)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .ir_we(ir_we), .pc_we(pc_we),
    .s_inc(s_inc), .s_inm(s_inm), .we(we), .wez(wez), .AluOP(AluOP),
    .push(push), .pop(pop), .s_ret(s_ret), .halted(halted), .err(err),
    .dbg_state(dbg_state_unused), .dbg_sp(dbg_sp)
  );

  // Field order: mem_req ir_we pc_we s_inc s_inm we wez AluOP push pop s_ret halted err sp
  logic [W-1:0] act;
  assign act = {mem_req, ir_we, pc_we, s_inc, s_inm, we, wez, AluOP,
                push, pop, s_ret, halted, err, dbg_sp};

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int checks = 0;
  int errors = 0;

  // Instruction-level model state.
  int         model_sp;
  logic       model_halt;
  logic [1:0] model_err;
  bit         dead;

  localparam logic [5:0] OP_LI   = 6'b100000;
  localparam logic [5:0] OP_ADD  = 6'b001000;
  localparam logic [5:0] OP_JZ   = 6'b101000;
  localparam logic [5:0] OP_JNZ  = 6'b101100;
  localparam logic [5:0] OP_JAL  = 6'b110000;
  localparam logic [5:0] OP_RET  = 6'b110100;
  localparam logic [5:0] OP_NOP  = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111100;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      checks++;
      if (act !== mon_exp) begin
        errors++;
        $display("FAIL outvec t=%0t got %b required %b (mr ir pw si sm we wz alu pu po sr h err sp)",
                 $time, act, mon_exp);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] vec(input logic mr, ir, pw, si, sm, w, wz,
                                       input logic [2:0] alu,
                                       input logic pu, po, sr, h,
                                       input logic [1:0] e, input int sp);
    logic [2:0] sp3;
    sp3 = 3'(sp);
    return {mr, ir, pw, si, sm, w, wz, alu, pu, po, sr, h, e, sp3};
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input logic rst, input logic [5:0] opc, input logic z,
                     input logic rdy, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    reset     = rst;
    Opcode    = opc;
    zero      = z;
    mem_ready = rdy;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    model_sp   = 0;
    model_halt = 1'b0;
    model_err  = 2'b00;
    dead       = 1'b0;
  endtask

  task automatic do_reset(input int n);
    model_reset();
    repeat (n) cyc(1'b0, rnd_op(), rnd_bit(), rnd_bit(), '0);
  endtask

  // Expected EXEC-cycle outputs for one instruction; updates the model.
  task automatic exec_model(input logic [5:0] op, input logic z, output logic [W-1:0] e);
    logic pw, si, sm, w, wz, pu, po, sr;
    logic [2:0] alu;
    int sp0;
    sp0 = model_sp;
    pw = 1; si = 1; sm = 0; w = 0; wz = 0; pu = 0; po = 0; sr = 0; alu = '0;
    if (!op[5]) begin
      w = 1; wz = 1; alu = op[4:2];
    end else begin
      case (op[4:2])
        3'd0: begin sm = 1; w = 1; end
        3'd1: si = 0;
        3'd2: si = ~z;
        3'd3: si = z;
        3'd4: begin
          if (model_sp < DEPTH) begin pu = 1; si = 0; model_sp++; end
          else begin pw = 0; model_err = 2'b10; dead = 1; end
        end
        3'd5: begin
          if (model_sp > 0) begin po = 1; sr = 1; model_sp--; end
          else begin pw = 0; model_err = 2'b11; dead = 1; end
        end
        3'd6: ;
        default: begin pw = 0; model_halt = 1; dead = 1; end
      endcase
    end
    e = vec(0, 0, pw, si, sm, w, wz, alu, pu, po, sr, 0, 2'b00, sp0);
  endtask

  // zsel: 0 / 1 forces zero in EXEC, 2 picks it at random.
  task automatic instr(input logic [5:0] op, input int waits, input int zsel);
    logic z;
    logic [W-1:0] e;
    for (int i = 0; i < waits && i <= WAIT_MAX; i++)
      cyc(1'b1, rnd_op(), rnd_bit(), 1'b0, vec(1,0,0,1,0,0,0,3'd0,0,0,0,0,2'b00,model_sp));
    if (waits > WAIT_MAX) begin
      model_err = 2'b01;
      dead      = 1'b1;
      return;
    end
    cyc(1'b1, rnd_op(), rnd_bit(), 1'b1, vec(1,1,0,1,0,0,0,3'd0,0,0,0,0,2'b00,model_sp));
    cyc(1'b1, op, rnd_bit(), rnd_bit(), vec(0,0,0,1,0,0,0,3'd0,0,0,0,0,2'b00,model_sp));
    z = (zsel == 2) ? rnd_bit() : (zsel == 1);
    exec_model(op, z, e);
    cyc(1'b1, rnd_op(), z, rnd_bit(), e);
  endtask

  // Reset arrives during EXEC: that cycle must show all outputs low.
  task automatic instr_abort(input logic [5:0] op);
    cyc(1'b1, rnd_op(), rnd_bit(), 1'b1, vec(1,1,0,1,0,0,0,3'd0,0,0,0,0,2'b00,model_sp));
    cyc(1'b1, op, rnd_bit(), rnd_bit(), vec(0,0,0,1,0,0,0,3'd0,0,0,0,0,2'b00,model_sp));
    model_reset();
    cyc(1'b0, rnd_op(), rnd_bit(), rnd_bit(), '0);
  endtask

  task automatic sticky(input int n);
    repeat (n)
      cyc(1'b1, rnd_op(), rnd_bit(), rnd_bit(),
          vec(0,0,0,1,0,0,0,3'd0,0,0,0,model_halt,model_err,model_sp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b0;
    Opcode    = '0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    do_reset(3);

    // LI, LI, ADD back-to-back: ir_we every third cycle.
    instr(OP_LI, 0, 2);
    instr(OP_LI, 0, 2);
    instr(OP_ADD, 0, 2);
    // Conditional jumps.
    instr(OP_JZ, 0, 1);
    instr(OP_JZ, 0, 0);
    instr(OP_JNZ, 0, 1);
    instr(OP_JNZ, 1, 0);

    // Call depth overflow.
    do_reset(2);
    repeat (5) instr(OP_JAL, 0, 2);
    sticky(5);

    // Return underflow.
    do_reset(2);
    instr(OP_RET, 0, 2);
    sticky(3);

    // Balanced call/return.
    do_reset(2);
    instr(OP_JAL, 0, 2);
    instr(OP_RET, 0, 2);
    instr(OP_NOP, 1, 2);

    // Fetch timeout and last-chance fetch.
    do_reset(2);
    instr(OP_NOP, WAIT_MAX + 1, 2);
    sticky(4);
    do_reset(2);
    instr(OP_NOP, WAIT_MAX, 2);
    instr(OP_ADD, 2, 2);

    // HALT.
    do_reset(2);
    instr(OP_HALT, 0, 2);
    sticky(4);

    // Reset during EXEC of an ADD, then normal restart.
    do_reset(2);
    instr_abort(OP_ADD);
    instr(OP_ADD, 0, 2);

    // Randomized instruction stream.
    do_reset(1);
    for (int n = 0; n < 300; n++) begin
      int waits;
      if (dead) begin
        sticky($urandom_range(1, 3));
        do_reset($urandom_range(1, 2));
      end
      waits = ($urandom_range(0, 19) == 0) ? WAIT_MAX + 1 : $urandom_range(0, 3);
      if ($urandom_range(0, 29) == 0)
        instr_abort(rnd_op());
      else
        instr(rnd_op(), waits, 2);
    end
    if (dead) sticky(2);

    // Let the monitor consume the last expected vector.
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/microc_ctrl_mc.md
Name: microc_ctrl_mc

Overview:
- Parametrised multi-cycle control unit for the microc datapath.
- Decodes the 6-bit Opcode and the zero flag, and generates s_inc, s_inm, we, wez and AluOP.
- Adds functions the hand-driven control lacks: fetch handshake with timeout, conditional jumps, a bounded call/return depth tracker, and sticky HALT/ERROR states.
- Sits between the instruction memory handshake and the microc datapath.

Parameters:
- DEPTH, default 4: maximum call nesting; width of the sp counter is clog2(DEPTH+1).
- WAIT_MAX, default 15: maximum cycles spent in FETCH waiting for mem_ready before ERROR.
- ALUOP_W, default 3: AluOP width; taken from Opcode[1+ALUOP_W:2].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Opcode  in  6  instruction opcode field from the datapath IR.
- zero  in  1  ALU zero flag from the datapath.
- mem_ready  in  1  instruction memory data valid.
- mem_req  out  1  instruction fetch request.
- ir_we  out  1  IR load strobe.
- pc_we  out  1  PC update strobe.
- s_inc  out  1  PC mux: 1 = PC+1, 0 = jump target.
- s_inm  out  1  regfile write-data mux: 1 = immediate, 0 = ALU.
- we  out  1  regfile write enable.
- wez  out  1  zero flag register write enable.
- AluOP  out  ALUOP_W  ALU operation.
- push  out  1  return-address stack push.
- pop  out  1  return-address stack pop.
- s_ret  out  1  PC mux override: 1 = return address.
- halted  out  1  HALT state reached.
- err  out  2  00 none, 01 fetch timeout, 10 stack overflow, 11 stack underflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = FETCH; sp = 0; op_r = 0; wait counter = 0; err = 00; halted = 0.
  - All outputs are 0 while reset is low, including mem_req.
  - Reset asserted mid-instruction aborts it: no pc_we or we is issued.
- States: FETCH, DECODE, EXEC, HALT, ERROR.
- FETCH:
  - mem_req = 1.
  - If mem_ready = 1: ir_we = 1 in the same cycle, clear the wait counter, next state DECODE.
  - Otherwise the counter increments. If mem_ready is still low in the cycle where counter == WAIT_MAX, go to ERROR with err = 01. Exactly WAIT_MAX+1 FETCH cycles are allowed.
- DECODE: op_r <= Opcode; next state EXEC. No strobes are driven.
- EXEC: one cycle, decode from op_r and the current zero input; pc_we = 1 unless stated otherwise; next state FETCH.
  - 0xxxxx ALU op: AluOP = op_r[1+ALUOP_W:2], we = 1, wez = 1, s_inm = 0, s_inc = 1.
  - 1000xx LI: s_inm = 1, we = 1, wez = 0, s_inc = 1.
  - 1001xx J: s_inc = 0.
  - 1010xx JZ: s_inc = ~zero.
  - 1011xx JNZ: s_inc = zero.
  - 1100xx JAL:
    - sp < DEPTH: push = 1, s_inc = 0, sp++.
    - sp == DEPTH: no push, pc_we = 0, go to ERROR with err = 10.
  - 1101xx RET:
    - sp > 0: pop = 1, s_ret = 1, sp--.
    - sp == 0: no pop, pc_we = 0, go to ERROR with err = 11.
  - 1110xx NOP: s_inc = 1.
  - 1111xx HALT: pc_we = 0, halted <= 1, go to HALT.
- Strobe and select rules:
  - we, wez, push, pop and pc_we are single-cycle strobes.
  - Outside EXEC: AluOP = 0, s_inc = 1, s_inm = 0, s_ret = 0, and all strobes are 0.
- HALT and ERROR are sticky until reset.
  - In both states mem_req = 0 and all strobes are 0.
  - halted stays 1 in HALT; err holds its code in ERROR.
- Timing: throughput is 3 cycles per instruction when mem_ready is already high in FETCH. A change in Opcode outside DECODE has no effect.

Test Plan:
- Reset release with mem_ready = 1; instruction sequence LI (100000), LI, ADD (001000) -> ir_we pulses at cycles 0, 3, 6. LI EXEC: s_inm = 1, we = 1, wez = 0. ADD EXEC: AluOP = 010, we = 1, wez = 1, s_inm = 0, s_inc = 1.
- JZ (101000) with zero = 1, then with zero = 0 -> s_inc = 0 then 1, with pc_we = 1 in both EXEC cycles. JNZ (101100) with zero = 1 -> s_inc = 1.
- DEPTH = 4: five consecutive JAL (110000) -> four push pulses, sp = 4. Fifth EXEC: no push, pc_we = 0, err = 10, mem_req stays 0 thereafter.
- After reset, RET (110100) with sp = 0 -> err = 11, pop = 0. Separately, JAL then RET -> push then pop with s_ret = 1, and sp returns to 0.
- mem_ready held 0 -> mem_req = 1 for 16 cycles, then ERROR with err = 01. Variant: mem_ready asserted on the 16th cycle -> ir_we = 1, no error.
- HALT (111100) -> halted = 1, no further mem_req. Assert reset low mid-EXEC of an ADD -> we is not asserted, all outputs are 0 immediately, and FETCH restarts after release.
